// File: rtl/cpld_bus_pkg.sv
// Shared definitions for the CPLD AVR-to-SRAM bridge.
// Command codes, access FSM states and default address width.
package cpld_bus_pkg;

  localparam int AWIDTH_DEF = 24;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_LOAD_A0   = 3'd1;
  localparam logic [2:0] CMD_LOAD_A1   = 3'd2;
  localparam logic [2:0] CMD_LOAD_A2   = 3'd3;
  localparam logic [2:0] CMD_WRITE_INC = 3'd4;
  localparam logic [2:0] CMD_READ_INC  = 3'd5;
  localparam logic [2:0] CMD_WRITE     = 3'd6;
  localparam logic [2:0] CMD_READ      = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_addr_counter.sv
// SRAM address register: byte-lane loads, increment and wrap pulse.
// Lanes above AWIDTH-1 are dropped when the address is narrower.
module sram_addr_counter
  import cpld_bus_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        i_ld,
  input  logic [7:0]        i_data,
  input  logic              i_inc,
  output logic [AWIDTH-1:0] o_addr,
  output logic              o_wrap
);

  localparam int EW = (AWIDTH > 24) ? AWIDTH : 24;

  logic [AWIDTH-1:0] r_addr;
  logic              r_wrap;
  logic [EW-1:0]     w_ext;
  logic [AWIDTH-1:0] w_nxt;

  always_comb begin
    w_ext = EW'(r_addr);
    if (i_ld[0]) w_ext[7:0]   = i_data;
    if (i_ld[1]) w_ext[15:8]  = i_data;
    if (i_ld[2]) w_ext[23:16] = i_data;
    w_nxt = w_ext[AWIDTH-1:0];
    if (i_inc) w_nxt = r_addr + AWIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_addr <= w_nxt;
      r_wrap <= i_inc && (&r_addr);
    end
  end

  assign o_addr = r_addr;
  assign o_wrap = r_wrap;

endmodule

// File: rtl/avr_sram_addr_seq.sv
// AVR command sequencer: address loads and timed SRAM access strobes.
// Access: SETUP, STROBE_CYCLES of strobe, HOLD, then optional increment.
module avr_sram_addr_seq
  import cpld_bus_pkg::*;
#(
  parameter int AWIDTH        = AWIDTH_DEF,
  parameter int STROBE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd,
  input  logic [7:0]        cmd_data,
  output logic              busy,
  output logic [AWIDTH-1:0] sram_addr,
  output logic              we_n,
  output logic              oe_n,
  output logic              wrap,
  output logic              overrun
);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_op_wr, r_op_inc;
  logic       r_busy, r_we_n, r_oe_n, r_ovr;
  logic       w_accept, w_access, w_inc;
  logic [2:0] w_ld;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_access = w_accept && cmd[2];
  assign w_ld[0]  = w_accept && (cmd == CMD_LOAD_A0);
  assign w_ld[1]  = w_accept && (cmd == CMD_LOAD_A1);
  assign w_ld[2]  = w_accept && (cmd == CMD_LOAD_A2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inc       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = S_STROBE;
        w_cnt_nxt   = 4'(STROBE_CYCLES);
      end
      S_STROBE: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_IDLE;
        w_inc       = r_op_inc;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op_wr  <= 1'b0;
      r_op_inc <= 1'b0;
      r_busy   <= 1'b0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      // op is latched at accept, well before STROBE is entered
      r_we_n  <= !((w_state_nxt == S_STROBE) && r_op_wr);
      r_oe_n  <= !((w_state_nxt == S_STROBE) && !r_op_wr);
      if (w_access) begin
        r_op_wr  <= (cmd == CMD_WRITE_INC) || (cmd == CMD_WRITE);
        r_op_inc <= (cmd == CMD_WRITE_INC) || (cmd == CMD_READ_INC);
      end
      if (cmd_valid && r_busy)
        r_ovr <= 1'b1;
      else if (w_ld[0])
        r_ovr <= 1'b0;
    end
  end

  sram_addr_counter #(
    .AWIDTH(AWIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .i_ld  (w_ld),
    .i_data(cmd_data),
    .i_inc (w_inc),
    .o_addr(sram_addr),
    .o_wrap(wrap)
  );

  assign busy    = r_busy;
  assign we_n    = r_we_n;
  assign oe_n    = r_oe_n;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_avr_sram_addr_seq.sv
// Scoreboard bench for avr_sram_addr_seq: directed cases plus random stream.
// Stimulus pushes expected accesses; a monitor checks strobes and timing.
module tb_avr_sram_addr_seq;

  localparam int AW = 24;
  localparam int SC = 3;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [7:0]    cmd_data;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic          we_n;
  logic          oe_n;
  logic          wrap;
  logic          overrun;

  avr_sram_addr_seq #(.AWIDTH(AW), .STROBE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .cmd_data (cmd_data),
    .busy     (busy),
    .sram_addr(sram_addr),
    .we_n     (we_n),
    .oe_n     (oe_n),
    .wrap     (wrap),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [23:0] after;
    bit          wrp;
    int          acc;
  } txn_t;

  txn_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] m_addr = '0;
  bit          m_ovr  = 0;
  bit          m_busy = 0;
  int          m_wait = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [2:0] c, input logic [7:0] d);
    bit          was_busy;
    txn_t        t;
    logic [24:0] sum;
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = v;
    cmd       = c;
    cmd_data  = d;
    was_busy  = (m_wait > 0);
    if (m_wait > 0) m_wait--;
    if (v && was_busy) begin
      m_ovr = 1;
    end else if (v) begin
      if (c == 3'd1) begin
        m_addr[7:0] = d;
        m_ovr = 0;
      end else if (c == 3'd2) begin
        m_addr[15:8] = d;
      end else if (c == 3'd3) begin
        m_addr[23:16] = d;
      end else if (c >= 3'd4) begin
        t.wr   = (c == 3'd4) || (c == 3'd6);
        t.addr = m_addr;
        t.acc  = cyc + 1;
        sum    = (c == 3'd4 || c == 3'd5) ? {1'b0, m_addr} + 25'd1
                                          : {1'b0, m_addr};
        t.after = sum[23:0];
        t.wrp   = sum[24];
        q.push_back(t);
        m_addr = t.after;
        m_wait = SC + 2;
      end
    end
    m_busy = (m_wait > 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cmd_data  = 8'd0;
    m_addr    = '0;
    m_ovr     = 0;
    m_wait    = 0;
    m_busy    = 0;
    q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0);
  endtask

  // monitor: samples just after each rising edge
  initial begin : monitor
    bit          prev_busy;
    bit          in_st;
    bit          st_done;
    bit          st_wr;
    int          st_start;
    int          st_len;
    logic [23:0] st_addr;
    bit          exp_wrap;
    txn_t        t;
    prev_busy = 0;
    in_st     = 0;
    st_done   = 0;
    st_wr     = 0;
    st_start  = 0;
    st_len    = 0;
    st_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        check("rst_addr", 32'(sram_addr), 32'h0);
        check("rst_we_n", 32'(we_n), 32'h1);
        check("rst_oe_n", 32'(oe_n), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        prev_busy = 0;
        in_st     = 0;
        st_done   = 0;
      end else begin
        exp_wrap = 0;
        if (!we_n && !oe_n) check("both_low", 32'h1, 32'h0);
        if (!we_n || !oe_n) begin
          if (!in_st) begin
            in_st    = 1;
            st_start = cyc;
            st_addr  = sram_addr;
            st_wr    = !we_n;
          end else begin
            check("addr_stable", 32'(sram_addr), 32'(st_addr));
            check("strobe_kind", 32'(!we_n), 32'(st_wr));
          end
          if (q.size() == 0) check("spurious_strobe", 32'h1, 32'h0);
        end else if (in_st) begin
          in_st   = 0;
          st_len  = cyc - st_start;
          st_done = 1;
        end
        if (prev_busy && !busy) begin
          if (q.size() == 0) begin
            check("unexpected_done", 32'h1, 32'h0);
          end else begin
            t = q.pop_front();
            check("strobe_seen", 32'(st_done), 32'h1);
            check("strobe_is_we", 32'(st_wr), 32'(t.wr));
            check("strobe_len", 32'(st_len), 32'(SC));
            check("strobe_start", 32'(st_start), 32'(t.acc + 1));
            check("addr_during", 32'(st_addr), 32'(t.addr));
            check("addr_after", 32'(sram_addr), 32'(t.after));
            check("busy_len", 32'(cyc), 32'(t.acc + SC + 2));
            exp_wrap = t.wrp;
          end
          st_done = 0;
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("wrap", 32'(wrap), 32'(exp_wrap));
        if (!busy) check("idle_addr", 32'(sram_addr), 32'(m_addr));
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = 3'd0;
    cmd_data  = 8'd0;
    do_reset();
    do_reset();

    step(1'b1, 3'd1, 8'h34);
    step(1'b1, 3'd2, 8'h12);
    step(1'b1, 3'd3, 8'h00);
    step(1'b0, 3'd0, 8'h00);
    check("load_addr", 32'(sram_addr), 32'h001234);
    check("load_busy", 32'(busy), 32'h0);

    step(1'b1, 3'd4, 8'h00);
    idle(SC + 4);
    check("winc_addr", 32'(sram_addr), 32'h001235);

    step(1'b1, 3'd1, 8'hFF);
    step(1'b1, 3'd2, 8'hFF);
    step(1'b1, 3'd3, 8'hFF);
    step(1'b1, 3'd5, 8'h00);
    idle(SC + 4);
    check("rinc_wrap_addr", 32'(sram_addr), 32'h0);

    step(1'b1, 3'd1, 8'h55);
    step(1'b1, 3'd7, 8'h00);
    step(1'b1, 3'd6, 8'h00);
    idle(SC + 4);
    check("ovr_sticky", 32'(overrun), 32'h1);
    check("read_no_inc", 32'(sram_addr), 32'h000055);
    step(1'b1, 3'd1, 8'h66);
    step(1'b0, 3'd0, 8'h00);
    check("ovr_clear", 32'(overrun), 32'h0);

    step(1'b1, 3'd6, 8'h00);
    step(1'b0, 3'd0, 8'h00);
    step(1'b0, 3'd0, 8'h00);
    do_reset();
    idle(SC + 4);

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), d);
    end
    idle(SC + 6);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avr_sram_addr_seq.md
Name: avr_sram_addr_seq

Overview:
- Upstream sequencer for the CPLD's AVR-to-SRAM data bridge.
- Accepts byte-wide commands from the AVR: address-byte loads, read/write requests.
- Owns the SRAM address, with auto-increment for block transfers.
- Generates timed active-low we_n/oe_n strobes. The downstream bus stage uses these strobes to buffer and steer data between the AVR and SRAM data buses.

Parameters:
- AWIDTH, 24: SRAM address width; address bits above AWIDTH-1 in loaded bytes are discarded.
- STROBE_CYCLES, 3: clk cycles that we_n/oe_n stay low per access; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present this cycle
- cmd  in  3  command code
- cmd_data  in  8  address byte for load commands; ignored otherwise
- busy  out  1  access in progress; commands not accepted
- sram_addr  out  AWIDTH  current SRAM address, registered
- we_n  out  1  SRAM write strobe, active low, registered
- oe_n  out  1  SRAM output-enable strobe, active low, registered
- wrap  out  1  one-cycle pulse when an increment wraps the address to 0
- overrun  out  1  sticky: a command arrived while busy

Behaviour:
- Reset values (synchronous, on the first clk edge with reset=1, including mid-access):
  - sram_addr=0, we_n=1, oe_n=1, busy=0, wrap=0, overrun=0
  - state=IDLE; strobe counter=0
- Command codes:
  - 0 NOP
  - 1 LOAD_A0: addr[7:0]
  - 2 LOAD_A1: addr[15:8]
  - 3 LOAD_A2: addr[23:16], truncated to AWIDTH
  - 4 WRITE_INC
  - 5 READ_INC
  - 6 WRITE
  - 7 READ
- Acceptance: a command is accepted on an edge where cmd_valid=1 and state=IDLE.
  - If cmd_valid=1 while busy=1: the command is dropped and overrun is set.
  - overrun clears on reset or on the next accepted LOAD_A0.
- Loads:
  - Update the selected byte at the accepting edge; other bytes are unchanged.
  - sram_addr shows the new value the next cycle.
  - busy stays 0; back-to-back loads are accepted every cycle.
- Access FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP on an accepted access command; op (write/read, inc) is latched.
  - SETUP, 1 cycle: address stable, both strobes high.
  - STROBE, STROBE_CYCLES cycles: we_n=0 for writes, oe_n=0 for reads; the counter counts down to 1, then goes to HOLD.
  - HOLD, 1 cycle: strobes high, address held for SRAM hold time.
  - HOLD -> IDLE. On this edge, if op is an _INC command, sram_addr <= sram_addr+1 modulo 2^AWIDTH.
  - If the increment takes all-ones to 0, wrap=1 for the first IDLE cycle only.
- Timing:
  - busy = (state != IDLE), registered; it is high for exactly STROBE_CYCLES+2 cycles per access.
  - The next command can be accepted on the first cycle busy=0.
  - Minimum access period is STROBE_CYCLES+3 cycles.
- Strobe invariants:
  - we_n and oe_n are never both low.
  - Strobes are never low outside STROBE.
  - sram_addr never changes while either strobe is low.
- Reset during STROBE: strobes return high on that edge; no increment is performed.
- NOP: accepted and has no effect.
- Unused high bits of cmd_data on LOAD_A2 (when AWIDTH<24) are ignored.

Decomposition:
- Shared package (cpld_bus_pkg) holds:
  - command code constants CMD_NOP..CMD_READ
  - state encoding constants S_IDLE/S_SETUP/S_STROBE/S_HOLD, 2 bits
  - default AWIDTH
- One sub-module, sram_addr_counter:
  - AWIDTH register with byte-lane load enables, increment enable, and wrap pulse output.
- The FSM and strobe counter stay in the top module.

Test Plan:
- Load cmd1 0x34, cmd2 0x12, cmd3 0x00 on consecutive cycles -> sram_addr=0x001234 after the third edge; busy stays 0; strobes stay high.
- From addr 0x001234, issue cmd4 (STROBE_CYCLES=3):
  - busy high for exactly 5 cycles
  - we_n low for exactly 3 cycles, starting 2 cycles after accept
  - oe_n stays 1
  - sram_addr=0x001235 when busy falls
- Addr 0xFFFFFF, issue cmd5 -> oe_n low 3 cycles; sram_addr=0x000000; wrap=1 for exactly one cycle.
- Issue cmd7 then cmd_valid=1 with cmd6 during busy -> second command dropped; overrun=1 and stays set; address unchanged after cmd7; a following cmd1 clears overrun.
- Assert reset in the second STROBE cycle of a write -> next cycle we_n=1, busy=0, sram_addr=0; no further strobe.
- Random command stream of 1000 commands -> checker confirms:
  - strobes never both low
  - address stable while a strobe is low
  - increment count matches accepted _INC commands modulo 2^AWIDTH
